ps2_key_rx: RTL

Receives PS/2 keyboard frames on PS2_CLK/PS2_DAT and decodes Set-2 make/break scancodes into ten held-key level signals for the two tank players. It is a drop-in replacement for the switch-based `p1_*`/`p2_*` controls feeding the two `Joystick` instances, and runs on the 25 MHz PLL clock. The block only receives; it never drives the PS/2 lines. The top level ties both lines to high-Z.

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_frame_rx.sv | 114 +++++++++++
 rtl/ps2_key_rx.sv | 96 +++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: Set-2 scancodes, frame FSM states and
// the frame parity helper.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  localparam logic [7:0] SC_P1_UP    = 8'h1D;  // W
  localparam logic [7:0] SC_P1_DOWN  = 8'h1B;  // S
  localparam logic [7:0] SC_P1_LEFT  = 8'h1C;  // A
  localparam logic [7:0] SC_P1_RIGHT = 8'h23;  // D
  localparam logic [7:0] SC_P1_FIRE  = 8'h29;  // Space
  localparam logic [7:0] SC_P2_UP    = 8'h75;  // E0-prefixed arrows
  localparam logic [7:0] SC_P2_DOWN  = 8'h72;
  localparam logic [7:0] SC_P2_LEFT  = 8'h6B;
  localparam logic [7:0] SC_P2_RIGHT = 8'h74;
  localparam logic [7:0] SC_P2_FIRE  = 8'h5A;  // Enter, main or keypad

  localparam logic [3:0] LAST_BIT = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } ps2_state_t;

  // data byte plus parity bit must carry an odd number of ones
  function automatic logic odd_parity(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchroniser, falling-edge detect, 11-bit frame
// FSM and inter-edge timeout. Emits one byte per good frame.
//
// state    | meaning
// ST_IDLE  | waiting for a start bit (data 0 on a falling edge)
// ST_SHIFT | collecting data[7:0], parity and stop, LSB first
// ST_CHECK | one-cycle turnaround after the verdict, then back to idle
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_code,
  output logic       o_code_valid,
  output logic       o_frame_err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = '1;

  logic clk_meta, clk_sync, clk_hist;
  logic dat_meta, dat_sync;
  logic fall;

  ps2_state_t    state;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;
  logic [TW-1:0] tmo_cnt;
  logic          good;

  // Lines idle high, so the flops reset high to avoid a phantom edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_hist <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= i_ps2_clk;
      clk_sync <= clk_meta;
      clk_hist <= clk_sync;
      dat_meta <= i_ps2_dat;
      dat_sync <= dat_meta;
    end
  end

  assign fall = clk_hist & ~clk_sync;

  // On the stop-bit edge the stop bit is still live on dat_sync.
  assign good = odd_parity(shreg) & dat_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= 4'd0;
      shreg        <= 9'd0;
      tmo_cnt      <= '0;
      o_code       <= 8'd0;
      o_code_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_code_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (fall && !dat_sync) begin
            state   <= ST_SHIFT;
            bit_cnt <= 4'd0;
          end
        end
        ST_SHIFT: begin
          if (fall) begin
            tmo_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              // verdict registered here so the pulse coincides with CHECK
              state <= ST_CHECK;
              if (good) begin
                o_code       <= shreg[7:0];
                o_code_valid <= 1'b1;
              end else begin
                o_frame_err <= 1'b1;
              end
            end else begin
              shreg   <= {dat_sync, shreg[8:1]};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            o_frame_err <= 1'b1;
            tmo_cnt     <= '0;
            state       <= ST_IDLE;
          end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          tmo_cnt <= '0;
          state   <= ST_IDLE;
        end
        default: begin
          tmo_cnt <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard to tank-player controls: receives Set-2 scancodes and keeps
// ten independent held-key levels from make/break codes.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_code,
  output logic       o_code_valid,
  output logic       o_frame_err,
  output logic       o_p1_up,
  output logic       o_p1_down,
  output logic       o_p1_left,
  output logic       o_p1_right,
  output logic       o_p1_fire,
  output logic       o_p2_up,
  output logic       o_p2_down,
  output logic       o_p2_left,
  output logic       o_p2_right,
  output logic       o_p2_fire
);

  logic ext;
  logic brk;
  logic make;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk         (clk),
    .rst         (rst),
    .i_ps2_clk   (i_ps2_clk),
    .i_ps2_dat   (i_ps2_dat),
    .o_code      (o_code),
    .o_code_valid(o_code_valid),
    .o_frame_err (o_frame_err)
  );

  assign make = ~brk;

  always_ff @(posedge clk) begin
    if (rst) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      o_p1_up    <= 1'b0;
      o_p1_down  <= 1'b0;
      o_p1_left  <= 1'b0;
      o_p1_right <= 1'b0;
      o_p1_fire  <= 1'b0;
      o_p2_up    <= 1'b0;
      o_p2_down  <= 1'b0;
      o_p2_left  <= 1'b0;
      o_p2_right <= 1'b0;
      o_p2_fire  <= 1'b0;
    end else if (o_frame_err) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (o_code_valid) begin
      // prefixes accumulate in any order; F0 E0 still decodes as extended break
      if (o_code == SC_EXT) begin
        ext <= 1'b1;
      end else if (o_code == SC_BRK) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (!ext) begin
          case (o_code)
            SC_P1_UP:    o_p1_up    <= make;
            SC_P1_DOWN:  o_p1_down  <= make;
            SC_P1_LEFT:  o_p1_left  <= make;
            SC_P1_RIGHT: o_p1_right <= make;
            SC_P1_FIRE:  o_p1_fire  <= make;
            default: ;
          endcase
        end else begin
          case (o_code)
            SC_P2_UP:    o_p2_up    <= make;
            SC_P2_DOWN:  o_p2_down  <= make;
            SC_P2_LEFT:  o_p2_left  <= make;
            SC_P2_RIGHT: o_p2_right <= make;
            default: ;
          endcase
        end
        if (o_code == SC_P2_FIRE) begin
          o_p2_fire <= make;
        end
      end
    end
  end

endmodule
